// File: rtl/regfile_pkg.sv
// Shared definitions for the parametrised register file.
// Holds the default geometry and a generic one-hot decode helper.
package regfile_pkg;

    localparam int unsigned DATA_W_DEF = 64;
    localparam int unsigned ADDR_W_DEF = 5;

    // Widest address the helper decoder handles; callers truncate the result
    localparam int unsigned MAX_ADDR_W = 10;
    localparam int unsigned MAX_NOUT   = 2**MAX_ADDR_W;

    // One-hot decode of a (zero-extended) address
    function automatic logic [MAX_NOUT-1:0] onehot_dec(input logic [MAX_ADDR_W-1:0] a);
        logic [MAX_NOUT-1:0] v;
        v    = '0;
        v[a] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/regfile_wbuf_dec.sv
// dec_param: ADDR_W-to-2**ADDR_W decoder with enable.
// Ports: en (enable), addr (ADDR_W), dec (2**ADDR_W one-hot, zero when en=0).
// Small widths decode flat; ADDR_W >= 3 uses a high-bit predecoder driving
// 8-way low decoders.
module dec_param
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic                   en,
    input  logic [ADDR_W-1:0]      addr,
    output logic [(2**ADDR_W)-1:0] dec
);

    localparam int unsigned NOUT = 2**ADDR_W;

    if (ADDR_W < 3) begin : g_flat
        assign dec = en ? NOUT'(onehot_dec(MAX_ADDR_W'(addr))) : '0;
    end else begin : g_tree
        localparam int unsigned HI_W = ADDR_W - 3;
        localparam int unsigned NHI  = 2**HI_W;

        logic [NHI-1:0] hi_en;

        // Predecode of the bits above the 8-way group
        if (HI_W == 0) begin : g_nohi
            assign hi_en = en;
        end else begin : g_hi
            assign hi_en = en ? NHI'(onehot_dec(MAX_ADDR_W'(addr[ADDR_W-1:3]))) : '0;
        end

        // One 8-way low decoder per predecoded group
        for (genvar g = 0; g < NHI; g++) begin : g_lo
            assign dec[g*8 +: 8] = hi_en[g] ? (8'd1 << addr[2:0]) : 8'd0;
        end
    end

endmodule

// File: rtl/regfile_wbuf.sv
// regfile_wbuf: register file with a one-entry registered write buffer.
// Ports:
//   clk, reset         rising-edge clock, synchronous active-high reset
//   RegWrite           write request this cycle
//   WriteRegister/Data write address / data, captured into the buffer
//   ReadRegister       NREAD packed read addresses (port k at [k*ADDR_W +: ADDR_W])
//   ReadData           NREAD packed combinational read data, bypassing the buffer
//   decoded            one-hot commit enable of the buffered write
//   pend_valid         buffer holds an uncommitted write
// With ZERO_REG != 0 the top register reads as zero and never commits.
module regfile_wbuf
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned NREAD    = 2,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      RegWrite,
    input  logic [ADDR_W-1:0]         WriteRegister,
    input  logic [DATA_W-1:0]         WriteData,
    input  logic [NREAD*ADDR_W-1:0]   ReadRegister,
    output logic [NREAD*DATA_W-1:0]   ReadData,
    output logic [(2**ADDR_W)-1:0]    decoded,
    output logic                      pend_valid
);

    localparam int unsigned       NREGS = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] ZADDR = ADDR_W'(NREGS - 1);

    logic [DATA_W-1:0] mem [NREGS];
    logic              pend_valid_q;
    logic [ADDR_W-1:0] pend_addr;
    logic [DATA_W-1:0] pend_data;
    logic              commit_en;

    // A buffered write to the zero register never produces a commit enable
    assign commit_en  = pend_valid_q && !((ZERO_REG != 0) && (pend_addr == ZADDR));
    assign pend_valid = pend_valid_q;

    dec_param #(.ADDR_W(ADDR_W)) u_dec (
        .en   (commit_en),
        .addr (pend_addr),
        .dec  (decoded)
    );

    // Commit the pending write, then capture this cycle's request; reset wins
    always_ff @(posedge clk) begin
        if (reset) begin
            mem          <= '{default: '0};
            pend_valid_q <= 1'b0;
            pend_addr    <= '0;
            pend_data    <= '0;
        end else begin
            if (decoded[pend_addr]) begin
                mem[pend_addr] <= pend_data;
            end
            pend_valid_q <= RegWrite;
            pend_addr    <= WriteRegister;
            pend_data    <= WriteData;
        end
    end

    // Independent read ports: zero register, then buffer bypass, then array
    for (genvar k = 0; k < NREAD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd;

        assign ra = ReadRegister[k*ADDR_W +: ADDR_W];

        always_comb begin
            rd = mem[ra];
            if ((ZERO_REG != 0) && (ra == ZADDR)) begin
                rd = '0;
            end else if (pend_valid_q && (pend_addr == ra)) begin
                rd = pend_data;
            end
        end

        assign ReadData[k*DATA_W +: DATA_W] = rd;
    end

endmodule

// File: tb/tb_regfile_wbuf.sv
// Self-checking bench for regfile_wbuf (DATA_W=64, ADDR_W=5, NREAD=2, ZERO_REG=1).
module tb_regfile_wbuf;

    logic         clk = 1'b0;
    logic         reset;
    logic         RegWrite;
    logic [4:0]   WriteRegister;
    logic [63:0]  WriteData;
    logic [9:0]   ReadRegister;
    logic [127:0] ReadData;
    logic [31:0]  decoded;
    logic         pend_valid;

    int checks = 0;
    int errors = 0;

    logic [63:0] exp_q [$];

    // Reference model state
    logic [63:0] m_mem [32];
    logic        m_pv;
    logic [4:0]  m_pa;
    logic [63:0] m_pd;

    always #5 clk = ~clk;

    regfile_wbuf #(
        .DATA_W   (64),
        .ADDR_W   (5),
        .NREAD    (2),
        .ZERO_REG (1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .ReadRegister  (ReadRegister),
        .ReadData      (ReadData),
        .decoded       (decoded),
        .pend_valid    (pend_valid)
    );

    function automatic logic [63:0] m_read(input logic [4:0] a);
        if (a == 5'd31) return 64'h0;
        if (m_pv && (m_pa == a)) return m_pd;
        return m_mem[a];
    endfunction

    function automatic logic [31:0] m_dec();
        if (m_pv && (m_pa != 5'd31)) return 32'd1 << m_pa;
        return 32'd0;
    endfunction

    task automatic m_update();
        if (reset) begin
            for (int i = 0; i < 32; i++) m_mem[i] = 64'h0;
            m_pv = 1'b0;
        end else begin
            if (m_pv && (m_pa != 5'd31)) m_mem[m_pa] = m_pd;
            m_pv = RegWrite;
            m_pa = WriteRegister;
            m_pd = WriteData;
        end
    endtask

    // Drive one cycle of stimulus after the falling edge and queue expected reads
    task automatic drive(input logic rst, input logic rw, input logic [4:0] wa,
                         input logic [63:0] wd, input logic [4:0] r0, input logic [4:0] r1);
        @(negedge clk);
        reset         = rst;
        RegWrite      = rw;
        WriteRegister = wa;
        WriteData     = wd;
        ReadRegister  = {r1, r0};
        exp_q.push_back(m_read(r0));
        exp_q.push_back(m_read(r1));
        #1;
    endtask

    task automatic clock();
        @(posedge clk);
        m_update();
        #1;
    endtask

    task automatic test_reset();
        logic [63:0] e;
        drive(1'b1, 1'b0, 5'd0, 64'h0, 5'd0, 5'd0);
        exp_q.delete();
        clock();
        // Preload the array
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, 5'(i * 3 + 1), {$urandom, $urandom}, 5'(i * 3 + 1), 5'(i * 3 - 2));
            for (int k = 0; k < 2; k++) begin
                e = exp_q.pop_front();
                checks++;
                if (ReadData[k*64 +: 64] !== e) begin
                    errors++;
                    $display("FAIL preload_rd%0d got %h exp %h", k, ReadData[k*64 +: 64], e);
                end
            end
            clock();
        end
        drive(1'b1, 1'b1, 5'd9, 64'h1234, 5'd1, 5'd4);
        void'(exp_q.pop_front());
        void'(exp_q.pop_front());
        clock();
        checks++;
        if (pend_valid !== 1'b0 || decoded !== 32'h0) begin
            errors++;
            $display("FAIL reset_state got pv=%b dec=%h exp pv=0 dec=0", pend_valid, decoded);
        end
        for (int a = 0; a < 32; a += 2) begin
            drive(1'b0, 1'b0, 5'd0, 64'h0, 5'(a), 5'(a + 1));
            for (int k = 0; k < 2; k++) begin
                e = exp_q.pop_front();
                checks++;
                if (ReadData[k*64 +: 64] !== 64'h0 || e !== 64'h0) begin
                    errors++;
                    $display("FAIL reset_rd a=%0d port%0d got %h exp 0", a, k, ReadData[k*64 +: 64]);
                end
            end
            clock();
        end
    endtask

    task automatic test_bypass();
        logic [63:0] e;
        // Cycle N: write 5, read 5 returns old data
        drive(1'b0, 1'b1, 5'd5, 64'hDEAD_BEEF_0000_0001, 5'd5, 5'd0);
        e = exp_q.pop_front();
        void'(exp_q.pop_front());
        checks++;
        if (ReadData[63:0] !== e || e !== 64'h0) begin
            errors++;
            $display("FAIL bypass_n got %h exp %h", ReadData[63:0], 64'h0);
        end
        clock();
        // Cycle N+1: bypassed value and commit enable for entry 5
        drive(1'b0, 1'b0, 5'd0, 64'h0, 5'd5, 5'd0);
        e = exp_q.pop_front();
        void'(exp_q.pop_front());
        checks++;
        if (ReadData[63:0] !== e || e !== 64'hDEAD_BEEF_0000_0001) begin
            errors++;
            $display("FAIL bypass_n1 got %h exp %h", ReadData[63:0], 64'hDEAD_BEEF_0000_0001);
        end
        checks++;
        if (decoded !== 32'h20 || pend_valid !== 1'b1) begin
            errors++;
            $display("FAIL bypass_dec got dec=%h pv=%b exp dec=00000020 pv=1", decoded, pend_valid);
        end
        clock();
        // Cycle N+2: value now comes from the array
        drive(1'b0, 1'b0, 5'd0, 64'h0, 5'd5, 5'd5);
        e = exp_q.pop_front();
        void'(exp_q.pop_front());
        checks++;
        if (ReadData[63:0] !== 64'hDEAD_BEEF_0000_0001 || pend_valid !== 1'b0) begin
            errors++;
            $display("FAIL bypass_n2 got %h pv=%b exp %h pv=0", ReadData[63:0], pend_valid, e);
        end
        clock();
    endtask

    task automatic test_back_to_back();
        logic [63:0] e;
        drive(1'b0, 1'b1, 5'd3, 64'h11, 5'd0, 5'd3);
        void'(exp_q.pop_front());
        void'(exp_q.pop_front());
        clock();
        drive(1'b0, 1'b1, 5'd3, 64'h22, 5'd0, 5'd3);
        void'(exp_q.pop_front());
        e = exp_q.pop_front();
        checks++;
        if (ReadData[127:64] !== 64'h11 || e !== 64'h11) begin
            errors++;
            $display("FAIL b2b_n1 got %h exp 11", ReadData[127:64]);
        end
        clock();
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 1'b0, 5'd0, 64'h0, 5'd0, 5'd3);
            void'(exp_q.pop_front());
            e = exp_q.pop_front();
            checks++;
            if (ReadData[127:64] !== 64'h22 || e !== 64'h22) begin
                errors++;
                $display("FAIL b2b_n%0d got %h exp 22", c + 2, ReadData[127:64]);
            end
            clock();
        end
    endtask

    task automatic test_zero_reg();
        drive(1'b0, 1'b1, 5'd31, 64'hFFFF, 5'd31, 5'd31);
        for (int k = 0; k < 2; k++) begin
            void'(exp_q.pop_front());
            checks++;
            if (ReadData[k*64 +: 64] !== 64'h0) begin
                errors++;
                $display("FAIL zero_rd_n port%0d got %h exp 0", k, ReadData[k*64 +: 64]);
            end
        end
        clock();
        checks++;
        if (pend_valid !== 1'b1 || decoded !== 32'h0) begin
            errors++;
            $display("FAIL zero_dec got pv=%b dec=%h exp pv=1 dec=0", pend_valid, decoded);
        end
        for (int c = 0; c < 2; c++) begin
            drive(1'b0, 1'b0, 5'd0, 64'h0, 5'd31, 5'd31);
            for (int k = 0; k < 2; k++) begin
                void'(exp_q.pop_front());
                checks++;
                if (ReadData[k*64 +: 64] !== 64'h0) begin
                    errors++;
                    $display("FAIL zero_rd_c%0d port%0d got %h exp 0", c, k, ReadData[k*64 +: 64]);
                end
            end
            clock();
        end
    endtask

    task automatic test_reset_mid_write();
        logic [63:0] e;
        drive(1'b0, 1'b1, 5'd7, 64'h55, 5'd7, 5'd0);
        void'(exp_q.pop_front());
        void'(exp_q.pop_front());
        clock();
        drive(1'b1, 1'b0, 5'd0, 64'h0, 5'd7, 5'd0);
        e = exp_q.pop_front();
        void'(exp_q.pop_front());
        checks++;
        if (ReadData[63:0] !== e) begin
            errors++;
            $display("FAIL rstmid_n1 got %h exp %h", ReadData[63:0], e);
        end
        clock();
        drive(1'b0, 1'b0, 5'd0, 64'h0, 5'd7, 5'd7);
        void'(exp_q.pop_front());
        void'(exp_q.pop_front());
        checks++;
        if (ReadData[63:0] !== 64'h0 || ReadData[127:64] !== 64'h0) begin
            errors++;
            $display("FAIL rstmid_n2 got %h exp 0", ReadData[63:0]);
        end
        clock();
    endtask

    task automatic test_random();
        logic [63:0] e;
        for (int c = 0; c < 3000; c++) begin
            drive(($urandom_range(0, 63) == 0), 1'($urandom), 5'($urandom), {$urandom, $urandom},
                  5'($urandom), 5'($urandom));
            for (int k = 0; k < 2; k++) begin
                e = exp_q.pop_front();
                checks++;
                if (ReadData[k*64 +: 64] !== e) begin
                    errors++;
                    $display("FAIL rand_rd c=%0d port%0d got %h exp %h", c, k, ReadData[k*64 +: 64], e);
                end
            end
            clock();
            checks++;
            if (decoded !== m_dec() || pend_valid !== m_pv || !$onehot0(decoded)) begin
                errors++;
                $display("FAIL rand_dec c=%0d got dec=%h pv=%b exp dec=%h pv=%b",
                         c, decoded, pend_valid, m_dec(), m_pv);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) m_mem[i] = 64'h0;
        m_pv          = 1'b0;
        m_pa          = 5'd0;
        m_pd          = 64'h0;
        reset         = 1'b1;
        RegWrite      = 1'b0;
        WriteRegister = 5'd0;
        WriteData     = 64'h0;
        ReadRegister  = 10'd0;

        test_reset();
        test_bypass();
        test_back_to_back();
        test_zero_reg();
        test_reset_mid_write();
        test_random();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
